mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master front end for the single-port 16x1k distributed memory (mem16x1k_dist_sch); sits directly upstream of it and drives its Write/Address/DataIn; consumes its DataOut.
- Shares the one memory port between the instruction-fetch master (read-only) and the data master (load/store).
- Req/ack handshake per master, round-robin on conflict, registered read data returned to the granted master.

Parameters:
- AW, 10, address width (1k words)
- DW, 16, data word width

Ports:
- CLK  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- IReq  in  1  fetch request, held until IAck
- IAddr  in  AW  fetch address
- IAck  out  1  one-cycle fetch completion pulse
- IData  out  DW  fetched word, valid when IAck=1, held until next fetch completes
- DReq  in  1  data request, held until DAck
- DWrite  in  1  1=store, 0=load; qualified by DReq
- DAddr  in  AW  data address
- DWData  in  DW  store data
- DAck  out  1  one-cycle data completion pulse (loads and stores)
- DRData  out  DW  load data, valid when DAck=1 after a load; unchanged by stores
- MemWrite  out  1  to memory Write
- MemAddr  out  AW  to memory Address
- MemDataIn  out  DW  to memory DataIn
- MemDataOut  in  DW  from memory DataOut (asynchronous read)

Behaviour:
- One clock (CLK); reset is synchronous and active-high (Reset). All outputs are registered.
- Reset values: IAck=0, DAck=0, IData=0, DRData=0, MemWrite=0, MemAddr=0, MemDataIn=0, state=IDLE, last-grant=I.
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE
  - Only IReq=1: go to GNT_I; MemAddr<=IAddr; MemWrite<=0.
  - Only DReq=1: go to GNT_D; MemAddr<=DAddr; MemDataIn<=DWData; MemWrite<=DWrite.
  - Both requests: grant the master not granted last; last-grant updated on every grant.
  - Neither: stay in IDLE; MemWrite=0.
- GNT_I / GNT_D (exactly one cycle; memory port driven from the latched registers)
  - Next edge: IData<=MemDataOut or DRData<=MemDataOut. DRData is loaded only when MemWrite=0.
  - Same edge: IAck<=1 or DAck<=1; MemWrite<=0; go to RESP.
  - A store is written by the memory at the edge leaving GNT_D. MemWrite is high for exactly one cycle per store.
- RESP (one cycle, ack high)
  - All requests are ignored.
  - Next edge: clear ack; go to IDLE.
  - Masters must drop or replace a request at the edge following ack.
- Timing:
  - Latency from the edge sampling a request in IDLE to the ack being high: 1 cycle.
  - Sustained throughput: one access per 3 cycles.
  - IAck and DAck are never high together.
- Request inputs are sampled only in IDLE. Address/data changes during GNT/RESP have no effect.
- DWrite is ignored when DReq=0.
- Reset mid-operation takes priority over all transitions:
  - Next edge forces IDLE and clears MemWrite, so an in-flight store asserted in the same cycle as Reset still completes only if Write was already high at that edge.
  - No ack is issued for an aborted access.
- Address wrap: no arithmetic; address 0x3FF is valid.

Test Plan:
- Reset, then DReq=1, DWrite=1, DAddr=0x001, DWData=0xBEEF -> MemWrite=1 for one cycle with MemAddr=0x001 and MemDataIn=0xBEEF; DAck pulses 1 cycle; DRData stays 0x0000.
- Then IReq=1, IAddr=0x001 -> MemAddr=0x001, MemWrite=0; IAck pulses 1 cycle later with IData=0xBEEF.
- Store 0x1234 at 0x3FF, then load (DWrite=0) from 0x3FF -> DAck with DRData=0x1234; IAck stays 0 throughout.
- IReq and DReq raised on the same edge, both held (last-grant=I after reset) -> D served first, then I. With both held continuously, grants alternate D,I,D,I, with acks exactly 3 cycles apart.
- Reset asserted during GNT_D of a load -> next cycle state=IDLE, DAck=0, MemWrite=0; DRData=0.
- Request held high through RESP -> not re-accepted until IDLE. A request still high in IDLE is served again, verified by an ack count of 2 over 6 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master front end for the single-port 16x1k distributed memory: the fetch master
// (read-only) and the data master (load/store) share the port, with round-robin on conflict.
//
// state | meaning
// IDLE  | port free; sample IReq/DReq and latch the winner's address/data
// GNT_I | port driven for a fetch; MemDataOut captured into IData at the next edge
// GNT_D | port driven for a load/store; a store is written at the edge leaving this state
// RESP  | ack high for one cycle; requests ignored
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IAck,
  output logic [DW-1:0] IData,
  input  logic          DReq,
  input  logic          DWrite,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DAck,
  output logic [DW-1:0] DRData,
  output logic          MemWrite,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemDataIn,
  input  logic [DW-1:0] MemDataOut
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  state_t state;
  logic   last_d;  // 1 when the data master received the most recent grant

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      IAck      <= 1'b0;
      DAck      <= 1'b0;
      IData     <= '0;
      DRData    <= '0;
      MemWrite  <= 1'b0;
      MemAddr   <= '0;
      MemDataIn <= '0;
    end else begin
      case (state)
        IDLE: begin
          IAck     <= 1'b0;
          DAck     <= 1'b0;
          MemWrite <= 1'b0;
          // On conflict the fetch master wins only if data was granted last.
          if (IReq && (!DReq || last_d)) begin
            state   <= GNT_I;
            MemAddr <= IAddr;
            last_d  <= 1'b0;
          end else if (DReq) begin
            state     <= GNT_D;
            MemAddr   <= DAddr;
            MemDataIn <= DWData;
            MemWrite  <= DWrite;
            last_d    <= 1'b1;
          end
        end
        GNT_I: begin
          IData    <= MemDataOut;
          IAck     <= 1'b1;
          MemWrite <= 1'b0;
          state    <= RESP;
        end
        GNT_D: begin
          if (!MemWrite) DRData <= MemDataOut;
          DAck     <= 1'b1;
          MemWrite <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          IAck  <= 1'b0;
          DAck  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory model on the port, directed steps plus randomized
// accesses checked against a transaction-level reference (array memory + round-robin rule).
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          IReq = 1'b0, DReq = 1'b0, DWrite = 1'b0;
  logic [AW-1:0] IAddr = '0, DAddr = '0;
  logic [DW-1:0] DWData = '0;
  logic          IAck, DAck, MemWrite;
  logic [DW-1:0] IData, DRData, MemDataIn, MemDataOut;
  logic [AW-1:0] MemAddr;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] seed(input int a);
    logic [31:0] t;
    t = a * 40503;
    return t[DW-1:0] ^ 16'h5A5A;
  endfunction

  // Memory downstream of the arbiter: asynchronous read, write on the rising edge.
  logic          mem_init = 1'b1;
  logic [DW-1:0] mem [1024];
  assign MemDataOut = mem[MemAddr];
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed(i);
    end else if (MemWrite) begin
      mem[MemAddr] <= MemDataIn;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] exp_idata, exp_drdata;
  bit            last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference effect of one completed grant.
  task automatic model_grant(input bit is_i, input bit wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    last_d = !is_i;
    if (is_i) exp_idata = ref_mem[a];
    else if (wr) ref_mem[a] = d;
    else exp_drdata = ref_mem[a];
  endtask

  task automatic chk_ack(input string tag, input bit is_i);
    chk({tag, "_ack"}, 32'({IAck, DAck}), is_i ? 32'd2 : 32'd1);
    chk({tag, "_idata"}, 32'(IData), 32'(exp_idata));
    chk({tag, "_drdata"}, 32'(DRData), 32'(exp_drdata));
    chk({tag, "_wr_low"}, 32'(MemWrite), 32'd0);
  endtask

  task automatic single(input bit is_i, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    @(negedge CLK);
    if (is_i) begin IReq = 1'b1; IAddr = a; end
    else begin DReq = 1'b1; DWrite = wr; DAddr = a; DWData = d; end
    @(negedge CLK);
    chk("gnt_addr", 32'(MemAddr), 32'(a));
    chk("gnt_write", 32'(MemWrite), 32'(!is_i && wr));
    if (!is_i && wr) chk("gnt_wdata", 32'(MemDataIn), 32'(d));
    chk("gnt_noack", 32'({IAck, DAck}), 32'd0);
    // Address/data churn after the grant must not disturb the access.
    IAddr = AW'($urandom); DAddr = AW'($urandom); DWData = DW'($urandom); DWrite = 1'($urandom);
    model_grant(is_i, wr, a, d);
    @(negedge CLK);
    chk_ack("single", is_i);
    IReq = 1'b0; DReq = 1'b0;
    @(negedge CLK);
    chk("single_ackclr", 32'({IAck, DAck}), 32'd0);
  endtask

  // Both masters request together and hold for n grants; acks land every 3 cycles.
  task automatic arb(input int n, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                     input bit wr, input logic [DW-1:0] d);
    bit win_i;
    @(negedge CLK);
    IReq = 1'b1; DReq = 1'b1; IAddr = ia; DAddr = da; DWrite = wr; DWData = d;
    for (int k = 0; k < n; k++) begin
      win_i = last_d;
      @(negedge CLK);
      chk("arb_addr", 32'(MemAddr), win_i ? 32'(ia) : 32'(da));
      chk("arb_write", 32'(MemWrite), 32'(!win_i && wr));
      chk("arb_noack", 32'({IAck, DAck}), 32'd0);
      model_grant(win_i, wr, win_i ? ia : da, d);
      @(negedge CLK);
      chk_ack("arb", win_i);
      if (k == n - 1) begin IReq = 1'b0; DReq = 1'b0; end
      @(negedge CLK);
      chk("arb_ackclr", 32'({IAck, DAck}), 32'd0);
    end
  endtask

  // Reset lands while a data access sits in GNT_D.
  task automatic reset_in_gnt(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge CLK);
    DReq = 1'b1; DWrite = wr; DAddr = a; DWData = d;
    @(negedge CLK);
    Reset = 1'b1;
    if (wr) ref_mem[a] = d;  // MemWrite is already high at the reset edge
    @(negedge CLK);
    chk("rst_ack", 32'({IAck, DAck}), 32'd0);
    chk("rst_wr", 32'(MemWrite), 32'd0);
    chk("rst_drdata", 32'(DRData), 32'd0);
    chk("rst_idata", 32'(IData), 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    Reset = 1'b0; DReq = 1'b0;
    exp_idata = '0; exp_drdata = '0; last_d = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 10'h3FF;
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
    exp_idata = '0; exp_drdata = '0; last_d = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_iack", 32'(IAck), 32'd0);
    chk("rst_dack", 32'(DAck), 32'd0);
    chk("rst_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    chk("rst_memdatain", 32'(MemDataIn), 32'd0);
    chk("rst_outdata", 32'({IData, DRData}), 32'd0);
    Reset = 1'b0; mem_init = 1'b0;

    // Stray DWrite without DReq must not write.
    @(negedge CLK); DWrite = 1'b1; DAddr = 10'h005; DWData = 16'hDEAD;
    @(negedge CLK);
    chk("idle_nowrite", 32'(MemWrite), 32'd0);
    DWrite = 1'b0;

    single(1'b0, 1'b1, 10'h001, 16'hBEEF);
    single(1'b1, 1'b0, 10'h001, 16'h0000);
    chk("fetch_beef", 32'(IData), 32'h0000BEEF);
    single(1'b0, 1'b1, 10'h3FF, 16'h1234);
    single(1'b0, 1'b0, 10'h3FF, 16'h0000);
    chk("load_1234", 32'(DRData), 32'h00001234);

    // After reset last grant is I, so D goes first on a tie.
    reset_in_gnt(1'b0, 10'h001, 16'h0000);
    arb(4, 10'h001, 10'h3FF, 1'b0, 16'h0000);

    // A fetch held for six cycles is served twice.
    @(negedge CLK);
    IReq = 1'b1; IAddr = 10'h3FF;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (IAck) cnt++;
    end
    IReq = 1'b0;
    model_grant(1'b1, 1'b0, 10'h3FF, '0);
    model_grant(1'b1, 1'b0, 10'h3FF, '0);
    chk("held_ack_count", 32'(cnt), 32'd2);
    chk("held_idata", 32'(IData), 32'(exp_idata));

    // Store interrupted by reset still lands; verify with a load.
    reset_in_gnt(1'b1, 10'h2A5, 16'hC0DE);
    single(1'b0, 1'b0, 10'h2A5, 16'h0000);
    chk("rst_store_kept", 32'(DRData), 32'h0000C0DE);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: single(1'b1, 1'b0, pick_addr(), '0);
        1: single(1'b0, 1'b0, pick_addr(), '0);
        2: single(1'b0, 1'b1, pick_addr(), DW'($urandom));
        default: arb($urandom_range(1, 4), pick_addr(), pick_addr(), 1'($urandom), DW'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
